// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a small byte FIFO and sticky error flags.
// Define UART_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 218,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  input  logic       rd_strobe,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       parity_err
);

  // state  | meaning
  // IDLE   | line idle, waiting for a falling edge
  // START  | timing to mid start bit, rejecting glitches
  // DATA   | sampling 8 data bits, LSB first
  // PARITY | sampling the even-parity bit (UART_PARITY_EN only)
  // STOP   | sampling the stop bit, pushing the byte if clean

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]  HALF_TC  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_TC   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              rxd_s1, rxd_s2, rxd_prev;
  logic              fall_edge, baud_tc, par_bad, push, pop, full;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_s1   <= rxd;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
    end
  end

  assign fall_edge = rxd_prev & ~rxd_s2;
  assign baud_tc   = (baud_cnt == BIT_TC);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      // Clear first so a same-cycle error event below takes priority.
      if (clr_err) begin
        frame_err <= 1'b0;
`ifdef UART_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
      case (state)
        IDLE: begin
          baud_cnt <= '0;
`ifdef UART_PARITY_EN
          par_bad <= 1'b0;
`endif
          if (fall_edge) state <= START;
        end
        START: begin
          if (baud_cnt == HALF_TC) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= rxd_s2 ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_tc) begin
            baud_cnt       <= '0;
            shift[bit_idx] <= rxd_s2;
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            state    <= STOP;
            if (rxd_s2 != ^shift) begin
              par_bad    <= 1'b1;
              parity_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            state    <= IDLE;
            if (!rxd_s2) frame_err <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_PARITY_EN
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign push = (state == STOP) && baud_tc && rxd_s2 && !par_bad;
  assign pop  = rd_strobe && (count != '0);
  assign full = (count == FULL_CNT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (clr_err) overrun <= 1'b0;
      // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
      if (push && (!full || pop)) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end else if (push) begin
        overrun <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !full && !pop)      count <= count + 1'b1;
      else if (pop && !push)          count <= count - 1'b1;
    end
  end

  assign rx_data  = mem[rd_ptr];
  assign rx_valid = (count != '0);

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial UART receive front-end for the SOC's memory-mapped UART peripheral; sits directly downstream of the RXD pin and upstream of the CPU data bus.
- Synchronises RXD, deserialises 8N1 frames (LSB first) and buffers completed bytes in a small FIFO.
- The CPU pops bytes through a single-cycle read strobe; errors are reported as sticky flags.

Parameters:
- CLKS_PER_BIT, 218, clock cycles per serial bit (10 MHz clk, 21.8 us bit period).
- FIFO_DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock, rising-edge.
- resetn  in  1  asynchronous active-low reset.
- rxd  in  1  serial input, idle high, asynchronous to clk.
- rd_strobe  in  1  pop head byte; 1-cycle pulse from the bus.
- clr_err  in  1  clears overrun, frame_err and parity_err.
- rx_data  out  8  FIFO head byte; valid only while rx_valid=1.
- rx_valid  out  1  FIFO not empty.
- overrun  out  1  sticky: a byte was dropped because the FIFO was full.
- frame_err  out  1  sticky: stop bit sampled low.
- parity_err  out  1  sticky parity mismatch; constant 0 without UART_PARITY_EN.

Behaviour:
- Reset (async assert, sync release):
  - rx_data=0, rx_valid=0, overrun=0, frame_err=0, parity_err=0.
  - FIFO pointers and count cleared; FSM to IDLE; bit counter and baud counter 0.
  - Synchroniser flops preset to 1.
- Synchroniser: 2-FF on rxd; a falling edge is detected when the registered previous value is 1 and the current synced value is 0.
- FSM states IDLE, START, DATA, STOP (plus PARITY with the macro):
  - IDLE: on falling edge -> START, baud counter cleared.
  - START: at count CLKS_PER_BIT/2-1, sample synced rxd. If 0 -> DATA, counter cleared, bit index 0. If 1 -> IDLE (glitch rejected, no flags set).
  - DATA: sample each time the counter reaches CLKS_PER_BIT-1, then clear the counter. Shift bit into bit[index] (LSB first). After index 7 -> STOP.
  - STOP: sample at CLKS_PER_BIT-1.
    - rxd=1: push byte; -> IDLE.
    - rxd=0: frame_err<=1; byte discarded; -> IDLE. A new frame needs rxd to return high first, because a falling edge requires a previous 1.
- Sample point is mid-bit. From the falling edge on the pin to rx_valid: 2 sync + 9.5*CLKS_PER_BIT + 1 cycles, ±1.
- FIFO:
  - rx_data is the registered head entry, presented combinationally from the array.
  - rx_valid = (count != 0).
  - Pointers wrap modulo FIFO_DEPTH.
- Push:
  - If not full, write and increment count.
  - If full with no simultaneous pop: byte dropped, overrun<=1, existing contents untouched.
- Pop: rd_strobe with rx_valid=1 advances the head next cycle. rd_strobe while empty is ignored, with no state change.
- Simultaneous push and pop: both take effect, count unchanged. When full, this counts as no overrun.
- Sticky flags:
  - Set by their events; cleared only by clr_err or reset.
  - If set and clear occur in the same cycle, set wins.
- Reset mid-frame aborts the frame; the partial byte is never pushed.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP, sampled at CLKS_PER_BIT-1. Even parity over the 8 data bits.
  - On mismatch: parity_err<=1 and the byte is discarded even if the stop bit is good. Frame_err is still checked.
- Undefined: no PARITY state; parity_err tied 0; plain 8N1.

Test Plan:
- Reset low 240 ns then high, then send 0x35 (8N1, 21.8 us/bit) -> rx_valid=1 with rx_data=0x35 within 2076±3 cycles of the start edge. Pulse rd_strobe -> rx_valid=0 next cycle.
- Send 0x35, 0x37, 0x38, 0x0D with no reads -> count=4. Four rd_strobe pulses return 0x35, 0x37, 0x38, 0x0D in order, then rx_valid=0, overrun=0.
- With FIFO full, send 0x41 -> overrun=1, contents unchanged. Repeat with rd_strobe coinciding with the push cycle -> no overrun, 0x41 becomes the last entry. Then clr_err -> overrun=0.
- Drive rxd low for 50 cycles then high -> no byte, no flags. Send 0x31 with stop bit forced 0 -> frame_err=1, rx_valid stays 0. The next clean 0x34 is received correctly.
- Assert resetn=0 during bit 4 of 0x33, release, send 0x0D -> only 0x0D appears, all flags 0.
- With UART_PARITY_EN, send 0x35 with wrong parity -> parity_err=1, no byte pushed. Correct parity -> 0x35 received.
